// File: rtl/tinker_pkg.sv
// Shared types for the tinker fetch front-end: fetch FSM states and prefetch queue entries.
// Pure declarations; no latency or backpressure of its own.
package tinker_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 64;
   localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h2000;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2,
      HALTED  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/tinker_fetch_queue.sv
// Prefetch FIFO of fetch entries: a push is visible at the head the next cycle (no bypass).
// Flush empties it in one cycle and beats a same-cycle push; a push into a full queue without a pop is dropped.
module tinker_fetch_queue
   import tinker_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push_i,
   input  fetch_entry_t         push_dat_i,
   input  logic                 pop_i,
   input  logic                 flush_i,
   output fetch_entry_t         head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the head is only observed while count_q is non-zero.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/tinker_fetch_unit.sv
// Fetch front-end: one outstanding 32-bit read, response queued and shown to decode the next cycle.
// Issues only while queue occupancy plus in-flight stays below DEPTH; TINKER_FETCH_PERF_EN adds perf counters.
module tinker_fetch_unit
   import tinker_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int                DEPTH    = 4
) (
   input  logic               clk,
   input  logic               reset,
   output logic               mem_req_valid,
   input  logic               mem_req_ready,
   output logic [ADDR_W-1:0]  mem_req_addr,
   input  logic               mem_resp_valid,
   input  logic [INSTR_W-1:0] mem_resp_data,
   output logic               inst_valid,
   input  logic               inst_ready,
   output logic [INSTR_W-1:0] inst_data,
   output logic [ADDR_W-1:0]  inst_pc,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
`ifdef TINKER_FETCH_PERF_EN
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_flushed,
`endif
   input  logic               halt
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
   logic [CNT_W-1:0]  q_count;
   fetch_entry_t      q_head, push_entry;
   logic              q_push, q_pop, q_flush, live, credit;

   // live: cycles in which the unit may act on inputs at all.
   assign live    = !reset && !halt && (state_q != HALTED);
   assign q_flush = live && redirect_valid;
   // In RUN nothing is outstanding, so credit reduces to queue occupancy.
   assign credit  = q_count < CNT_W'(DEPTH);

   assign mem_req_valid = live && !redirect_valid && (state_q == RUN) && credit;
   assign mem_req_addr  = mem_req_valid ? fetch_pc_q : '0;
   assign inst_valid    = live && !redirect_valid && (q_count != '0);
   assign inst_data     = inst_valid ? q_head.instr : '0;
   assign inst_pc       = inst_valid ? q_head.pc : '0;
   assign q_pop         = inst_valid && inst_ready;
   assign push_entry    = '{pc: issued_pc_q, instr: mem_resp_data};

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      issued_pc_d = issued_pc_q;
      q_push      = 1'b0;
      if (halt) begin
         state_d = HALTED;
      end else begin
         case (state_q)
            RUN: begin
               if (redirect_valid) begin
                  fetch_pc_d = word_align(redirect_pc);
               end else if (mem_req_valid && mem_req_ready) begin
                  issued_pc_d = fetch_pc_q;
                  fetch_pc_d  = fetch_pc_q + ADDR_W'(4);
                  state_d     = WAIT;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  fetch_pc_d = word_align(redirect_pc);
                  state_d    = mem_resp_valid ? RUN : DISCARD;
               end else if (mem_resp_valid) begin
                  q_push  = 1'b1;
                  state_d = RUN;
               end
            end
            DISCARD: begin
               // The stale response is dropped even if another redirect lands with it.
               if (redirect_valid) fetch_pc_d = word_align(redirect_pc);
               if (mem_resp_valid) state_d = RUN;
            end
            default: state_d = HALTED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         fetch_pc_q  <= RESET_PC;
         issued_pc_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         issued_pc_q <= issued_pc_d;
      end
   end

   tinker_fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .push_i     (q_push),
      .push_dat_i (push_entry),
      .pop_i      (q_pop),
      .flush_i    (q_flush),
      .head_o     (q_head),
      .count_o    (q_count)
   );

`ifdef TINKER_FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_flushed_q;
   logic [32:0] fetched_sum, flushed_sum;
   logic        drop_resp;

   assign drop_resp   = live && mem_resp_valid &&
                        (((state_q == WAIT) && redirect_valid) || (state_q == DISCARD));
   assign fetched_sum = {1'b0, perf_fetched_q} + 33'(q_push);
   assign flushed_sum = {1'b0, perf_flushed_q} + 33'(q_flush ? q_count : '0) + 33'(drop_resp);

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         perf_fetched_q <= fetched_sum[32] ? '1 : fetched_sum[31:0];
         perf_flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Directed bench for tinker_fetch_unit: in-order memory model plus a scoreboard of accepted fetch PCs.
module tb_tinker_fetch_unit;

   logic        clk;
   logic        reset;
   logic        mem_req_valid, mem_req_ready;
   logic [63:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst_data;
   logic [63:0] inst_pc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        halt;
`ifdef TINKER_FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed;
`endif

   tinker_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
`ifdef TINKER_FETCH_PERF_EN
      .perf_fetched   (perf_fetched),
      .perf_flushed   (perf_flushed),
`endif
      .halt           (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_pop    = 0;
   int          resp_wait = 0;
   int          resp_lat  = 1;
   int          halt_issued;
   logic        halted_exp = 1'b0;
   logic [63:0] resp_addr = '0;
   logic [63:0] last_pop_pc = '0;
   logic [63:0] sb[$];
   logic [63:0] issued[$];
   logic        s_req_vld, s_inst_vld;
   logic [63:0] s_req_addr, s_inst_pc;

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'hDEAD_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs at the falling edge, then drive next inputs just after the rising edge.
   task automatic tick();
      logic [63:0] exp_pc;
      @(negedge clk);
      s_req_vld  = mem_req_valid;
      s_req_addr = mem_req_addr;
      s_inst_vld = inst_valid;
      s_inst_pc  = inst_pc;
      if (halted_exp) begin
         check("halted_req_vld", {63'd0, mem_req_valid}, 64'd0);
         check("halted_inst_vld", {63'd0, inst_valid}, 64'd0);
      end
      if (inst_valid && inst_ready) begin
         n_pop++;
         last_pop_pc = inst_pc;
         check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            exp_pc = sb.pop_front();
            check("inst_pc", inst_pc, exp_pc);
            check("inst_data", {32'd0, inst_data}, {32'd0, word_of(exp_pc)});
         end
      end
      if (redirect_valid && !halt && !halted_exp) sb.delete();
      if (mem_req_valid && mem_req_ready) begin
         issued.push_back(mem_req_addr);
         sb.push_back(mem_req_addr);
         resp_addr = mem_req_addr;
         resp_wait = resp_lat;
      end
      if (halt) halted_exp = 1'b1;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (resp_wait > 0) begin
         resp_wait--;
         if (resp_wait == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = word_of(resp_addr);
         end
      end
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      resp_wait      = 0;
      resp_lat       = 1;
      repeat (2) @(posedge clk);
      #1;
      reset      = 1'b0;
      halted_exp = 1'b0;
      n_pop      = 0;
      sb.delete();
      issued.delete();
   endtask

   initial begin
      reset          = 1'b1;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      halt           = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_vld", {63'd0, mem_req_valid}, 64'd0);
      check("rst_req_addr", mem_req_addr, 64'd0);
      check("rst_inst_vld", {63'd0, inst_valid}, 64'd0);
      check("rst_inst_data", {32'd0, inst_data}, 64'd0);
      check("rst_inst_pc", inst_pc, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Streaming with 1-cycle memory and always-ready decode
      tick();
      check("t1_first_req_vld", {63'd0, s_req_vld}, 64'd1);
      check("t1_first_req_addr", s_req_addr, 64'h2000);
      tick();
      check("t1_inst_vld_resp_cycle", {63'd0, s_inst_vld}, 64'd0);
      tick();
      check("t1_inst_vld_after_resp", {63'd0, s_inst_vld}, 64'd1);
      check("t1_inst_pc_first", s_inst_pc, 64'h2000);
      for (int i = 0; i < 30 && n_pop < 3; i++) tick();
      check("t1_pops", 64'(n_pop), 64'd3);
      check("t1_issue0", issued[0], 64'h2000);
      check("t1_issue1", issued[1], 64'h2004);
      check("t1_issue2", issued[2], 64'h2008);

      // Decode stalled: queue fills to DEPTH and issue stops
      do_reset();
      inst_ready = 1'b0;
      repeat (20) tick();
      check("t2_issued_count", 64'(issued.size()), 64'd4);
      check("t2_req_vld_full", {63'd0, s_req_vld}, 64'd0);
      check("t2_head_vld", {63'd0, s_inst_vld}, 64'd1);
      check("t2_head_pc", s_inst_pc, 64'h2000);
      inst_ready = 1'b1;
      for (int i = 0; i < 30 && (n_pop < 4 || issued.size() < 5); i++) tick();
      check("t2_pops", 64'(n_pop >= 4), 64'd1);
      check("t2_resume_count", 64'(issued.size() >= 5), 64'd1);
      if (issued.size() >= 5) check("t2_resume_addr", issued[4], 64'h2010);

      // Redirect while waiting; stale response follows a cycle later
      do_reset();
      resp_lat = 2;
      tick();
      check("t3_req_addr", s_req_addr, 64'h2000);
      resp_lat       = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3002;
      tick();
      check("t3_redir_req_vld", {63'd0, s_req_vld}, 64'd0);
      check("t3_redir_inst_vld", {63'd0, s_inst_vld}, 64'd0);
      tick();
      check("t3_discard_req_vld", {63'd0, s_req_vld}, 64'd0);
      tick();
      check("t3_new_req_vld", {63'd0, s_req_vld}, 64'd1);
      check("t3_new_req_addr", s_req_addr, 64'h3000);
      for (int i = 0; i < 20 && n_pop < 1; i++) tick();
      check("t3_pops", 64'(n_pop), 64'd1);
      check("t3_first_pc", last_pop_pc, 64'h3000);

      // Redirect coinciding with a response while two entries are queued
      do_reset();
      inst_ready = 1'b0;
      repeat (5) tick();
      check("t4_pre_head_vld", {63'd0, s_inst_vld}, 64'd1);
      check("t4_pre_resp", {63'd0, mem_resp_valid}, 64'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h4000;
      tick();
      check("t4_redir_inst_vld", {63'd0, s_inst_vld}, 64'd0);
      tick();
      check("t4_empty_after", {63'd0, s_inst_vld}, 64'd0);
      check("t4_req_vld", {63'd0, s_req_vld}, 64'd1);
      check("t4_req_addr", s_req_addr, 64'h4000);
      inst_ready = 1'b1;
      for (int i = 0; i < 20 && n_pop < 1; i++) tick();
      check("t4_pops", 64'(n_pop), 64'd1);
      check("t4_first_pc", last_pop_pc, 64'h4000);

      // Memory not ready: request held stable
      do_reset();
      mem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_hold_vld", {63'd0, s_req_vld}, 64'd1);
         check("t5_hold_addr", s_req_addr, 64'h2000);
      end
      mem_req_ready = 1'b1;
      tick();
      check("t5_accept_count", 64'(issued.size()), 64'd1);

      // Halt with simultaneous redirect, then a later redirect while halted
      repeat (6) tick();
      halt           = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'h5000;
      tick();
      halt        = 1'b0;
      halt_issued = issued.size();
      for (int i = 0; i < 15; i++) begin
         if (i == 5) begin
            redirect_valid = 1'b1;
            redirect_pc    = 64'h6000;
         end
         tick();
      end
      check("t6_no_issue_halted", 64'(issued.size()), 64'(halt_issued));

      // Reset is the only way out of HALTED
      do_reset();
      tick();
      check("t6_reset_req_vld", {63'd0, s_req_vld}, 64'd1);
      check("t6_reset_req_addr", s_req_addr, 64'h2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
